// File: rtl/spi_target.sv
// SPI mode-1 target with CPU register port, byte-wide RX/TX FIFOs and level interrupt.
// All SPI pins are asynchronous and sampled through 2-flop synchronizers into i_clk.
module spi_target #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cs,
    input  logic       i_rwb,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       i_spi_cs,
    input  logic       i_spi_clk,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic       o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // bit 0 = CS, bit 1 = SCLK, bit 2 = MOSI; idle bus is CS high, SCLK low
    localparam logic [2:0] SYNC_IDLE = 3'b001;

    logic [2:0]    meta_reg;
    logic [2:0]    sync_reg;
    logic [1:0]    prev_reg;
    logic [1:0]    settle_reg;
    logic          armed_reg;

    logic          cs_sync;
    logic          sclk_sync;
    logic          mosi_sync;
    logic          cs_fall;
    logic          sclk_rise;
    logic          sclk_fall;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr_reg;
    logic [AW-1:0] rx_rd_ptr_reg;
    logic [AW:0]   rx_cnt_reg;
    logic [AW-1:0] tx_wr_ptr_reg;
    logic [AW-1:0] tx_rd_ptr_reg;
    logic [AW:0]   tx_cnt_reg;

    logic          rx_empty;
    logic          rx_full;
    logic          tx_empty;
    logic          tx_full;

    logic          enable_reg;
    logic          irq_en_reg;
    logic          overrun_reg;
    logic          underrun_reg;
    logic          irq_reg;

    logic [1:0]    state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    tx_shift_reg;
    logic [7:0]    rx_shift_reg;

    logic          wr_en;
    logic          ctrl_wr;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push_req;
    logic          rx_push;
    logic          rx_pop;
    logic [7:0]    rx_byte;
    logic          overrun_set;
    logic          underrun_set;
    logic [7:0]    status;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            meta_reg   <= SYNC_IDLE;
            sync_reg   <= SYNC_IDLE;
            prev_reg   <= SYNC_IDLE[1:0];
            settle_reg <= 2'd0;
            armed_reg  <= 1'b0;
        end else begin
            meta_reg <= {i_spi_mosi, i_spi_clk, i_spi_cs};
            sync_reg <= meta_reg;
            prev_reg <= sync_reg[1:0];
            if (settle_reg != 2'd2) begin
                settle_reg <= settle_reg + 2'd1;
            end
            // a transaction already running at reset release must see CS high before it counts
            if (settle_reg == 2'd2 && sync_reg[0]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign cs_sync   = sync_reg[0];
    assign sclk_sync = sync_reg[1];
    assign mosi_sync = sync_reg[2];
    assign cs_fall   = armed_reg & prev_reg[0] & ~cs_sync;
    assign sclk_rise = ~prev_reg[1] & sclk_sync;
    assign sclk_fall = prev_reg[1] & ~sclk_sync;

    assign rx_empty = (rx_cnt_reg == '0);
    assign rx_full  = (rx_cnt_reg == FULL_CNT);
    assign tx_empty = (tx_cnt_reg == '0);
    assign tx_full  = (tx_cnt_reg == FULL_CNT);

    assign wr_en   = i_cs & ~i_rwb;
    assign ctrl_wr = wr_en & (i_addr == 2'd3);
    assign tx_push = wr_en & (i_addr == 2'd1) & ~tx_full;
    assign rx_pop  = i_cs & i_rwb & (i_addr == 2'd0) & ~rx_empty;

    assign tx_pop       = enable_reg & (state_reg == ST_LOAD) & ~tx_empty;
    assign underrun_set = enable_reg & (state_reg == ST_LOAD) & tx_empty;

    assign rx_byte     = {rx_shift_reg[6:0], mosi_sync};
    assign rx_push_req = enable_reg & (state_reg == ST_SHIFT) & ~cs_sync &
                         sclk_fall & (bit_cnt_reg == 3'd7);
    assign rx_push     = rx_push_req & ~rx_full;
    assign overrun_set = rx_push_req & rx_full;

    always_ff @(posedge i_clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= rx_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_cnt_reg    <= '0;
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_cnt_reg    <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            end
            rx_cnt_reg <= rx_cnt_reg + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
            if (tx_push) begin
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            end
            tx_cnt_reg <= tx_cnt_reg + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            enable_reg   <= 1'b0;
            irq_en_reg   <= 1'b0;
            overrun_reg  <= 1'b0;
            underrun_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_reg <= i_data[0];
                irq_en_reg <= i_data[1];
            end
            // a new event in the same cycle as the clear keeps the flag set
            overrun_reg  <= overrun_set  | (overrun_reg  & ~(ctrl_wr & i_data[7]));
            underrun_reg <= underrun_set | (underrun_reg & ~(ctrl_wr & i_data[6]));
            irq_reg      <= irq_en_reg & (~rx_empty | overrun_reg);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            tx_shift_reg <= 8'hFF;
            rx_shift_reg <= 8'hFF;
        end else if (!enable_reg) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_shift_reg <= tx_empty ? 8'hFF : tx_mem[tx_rd_ptr_reg];
                    bit_cnt_reg  <= 3'd0;
                    state_reg    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cs_sync) begin
                        state_reg   <= ST_IDLE;
                        bit_cnt_reg <= 3'd0;
                    end else begin
                        // MSB is already on MISO after LOAD, so the first rising edge keeps it
                        if (sclk_rise && bit_cnt_reg != 3'd0) begin
                            tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
                        end
                        if (sclk_fall) begin
                            rx_shift_reg <= rx_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg <= 3'd0;
                                state_reg   <= ST_LOAD;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    bit_cnt_reg <= 3'd0;
                end
            endcase
        end
    end

    assign status = {1'b0, ~cs_sync & enable_reg, underrun_reg, overrun_reg,
                     tx_full, tx_empty, rx_full, ~rx_empty};

    always_comb begin
        o_data = 8'h00;
        case (i_addr)
            2'd0:    o_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
            2'd2:    o_data = status;
            2'd3:    o_data = {6'b0, irq_en_reg, enable_reg};
            default: o_data = 8'h00;
        endcase
    end

    assign o_spi_miso = (enable_reg && state_reg != ST_IDLE) ? tx_shift_reg[7] : 1'b1;
    assign o_irq      = irq_reg;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed scenarios plus randomized sessions
// compared against a queue-based model of the register and FIFO behaviour.
module tb_spi_target;

    localparam int DEPTH = 4;
    localparam int HALF  = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       rwb = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       spi_cs = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       miso;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_en = 1'b0;
    logic       m_irq_en = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_und = 1'b0;
    logic [7:0] mbuf [0:7];

    always #5 clk = ~clk;

    spi_target #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_cs       (cs),
        .i_rwb      (rwb),
        .i_addr     (addr),
        .i_data     (wdata),
        .o_data     (rdata),
        .i_spi_cs   (spi_cs),
        .i_spi_clk  (spi_clk),
        .i_spi_mosi (spi_mosi),
        .o_spi_miso (miso),
        .o_irq      (irq)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {1'b0, m_en & ~spi_cs, m_und, m_ovr,
                tx_q.size() == DEPTH, tx_q.size() == 0,
                rx_q.size() == DEPTH, rx_q.size() != 0};
    endfunction

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_en = 1'b0;
        m_irq_en = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rwb = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0;
        $display("cpu write addr=%0d data=%02h", a, d);
        case (a)
            2'd1: if (tx_q.size() < DEPTH) tx_q.push_back(d);
            2'd3: begin
                if (d[6]) m_und = 1'b0;
                if (d[7]) m_ovr = 1'b0;
                m_en = d[0];
                m_irq_en = d[1];
            end
            default: ;
        endcase
    endtask

    task automatic cpu_read_rx();
        logic [7:0] exp;
        @(negedge clk);
        cs = 1'b1; rwb = 1'b1; addr = 2'd0;
        #1;
        exp = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        check("rx_data", rdata, exp);
        $display("cpu read rx data=%02h", rdata);
        @(negedge clk);
        cs = 1'b0; rwb = 1'b0;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
    endtask

    task automatic check_regs();
        @(negedge clk);
        cs = 1'b0; addr = 2'd2;
        #1;
        check("status", rdata, model_status());
        addr = 2'd3;
        #1;
        check("control", rdata, {6'b0, m_irq_en, m_en});
        check("irq", {7'b0, irq}, {7'b0, m_irq_en & ((rx_q.size() != 0) | m_ovr)});
        addr = 2'd1;
        #1;
        check("addr1_read", rdata, 8'h00);
        $display("regs status=%02h irq=%0d", model_status(), irq);
    endtask

    task automatic clock_bits(input logic [7:0] data, input int first, input int nbits,
                              output logic [7:0] got);
        got = 8'h00;
        for (int k = first; k < first + nbits; k++) begin
            spi_clk = 1'b1;
            spi_mosi = data[7-k];
            #HALF;
            got[7-k] = miso;
            spi_clk = 1'b0;
            #HALF;
        end
    endtask

    // One CS-low session: nfull complete bytes, then 'partial' extra bits before CS rises.
    // Each byte slot (including the one following the last complete byte) consumes a TX entry.
    task automatic spi_session(input int nfull, input int partial);
        logic [7:0] exp_miso [0:7];
        logic [7:0] got;
        for (int i = 0; i <= nfull; i++) begin
            if (!m_en) begin
                exp_miso[i] = 8'hFF;
            end else if (tx_q.size() != 0) begin
                exp_miso[i] = tx_q.pop_front();
            end else begin
                exp_miso[i] = 8'hFF;
                m_und = 1'b1;
            end
        end
        for (int i = 0; i < nfull; i++) begin
            if (m_en) begin
                if (rx_q.size() == DEPTH) m_ovr = 1'b1;
                else rx_q.push_back(mbuf[i]);
            end
        end
        $display("spi session bytes=%0d extra_bits=%0d enable=%0d", nfull, partial, m_en);
        spi_cs = 1'b0;
        #HALF;
        addr = 2'd2;
        #1;
        check("busy", {7'b0, rdata[6]}, {7'b0, m_en});
        for (int b = 0; b <= nfull; b++) begin
            clock_bits(mbuf[b], 0, (b == nfull) ? partial : 8, got);
            if (b < nfull) begin
                check($sformatf("miso_byte%0d", b), got, exp_miso[b]);
                $display("spi byte mosi=%02h miso=%02h", mbuf[b], got);
            end
        end
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        #HALF;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain_rx();
        while (rx_q.size() != 0) cpu_read_rx();
    endtask

    initial begin
        logic [7:0] dummy;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("miso_reset", {7'b0, miso}, 8'h01);
        check_regs();
        cpu_read_rx();

        // basic exchange
        cpu_write(2'd3, 8'h01);
        cpu_write(2'd1, 8'h55);
        mbuf[0] = 8'hAA;
        spi_session(1, 0);
        cpu_read_rx();
        check_regs();

        // TX underrun, then write-1-clear
        mbuf[0] = 8'h3C;
        spi_session(1, 0);
        check_regs();
        cpu_write(2'd3, 8'h40);
        check_regs();
        drain_rx();

        // overrun with irq enabled
        cpu_write(2'd3, 8'hC3);
        for (int i = 0; i < 5; i++) mbuf[i] = 8'(i + 1);
        spi_session(5, 0);
        check_regs();
        for (int i = 0; i < 5; i++) cpu_read_rx();
        check_regs();
        cpu_write(2'd3, 8'hC1);

        // aborted byte followed by a full one
        mbuf[0] = 8'h5A;
        spi_session(0, 4);
        mbuf[0] = 8'hC3;
        spi_session(1, 0);
        check_regs();
        drain_rx();

        // back-to-back bytes from a preloaded TX FIFO
        cpu_write(2'd1, 8'h12);
        cpu_write(2'd1, 8'h34);
        mbuf[0] = 8'hE1; mbuf[1] = 8'h7E;
        spi_session(2, 0);
        check_regs();
        drain_rx();

        // reset asserted mid-byte, controller keeps clocking through release
        cpu_write(2'd3, 8'h03);
        cpu_write(2'd1, 8'h99);
        mbuf[0] = 8'hB4;
        spi_cs = 1'b0;
        #HALF;
        clock_bits(mbuf[0], 0, 4, dummy);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("miso_in_reset", {7'b0, miso}, 8'h01);
        check("irq_in_reset", {7'b0, irq}, 8'h00);
        addr = 2'd2;
        #1;
        check("status_in_reset", rdata, 8'h04);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset pulse during transfer");
        clock_bits(mbuf[0], 4, 4, dummy);
        spi_cs = 1'b1;
        #HALF;
        check_regs();
        cpu_write(2'd3, 8'h01);
        cpu_write(2'd1, 8'h6D);
        mbuf[0] = 8'h2B;
        spi_session(1, 0);
        check_regs();
        drain_rx();

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            int npush, nread, nfull, partial;
            npush = $urandom_range(0, 5);
            for (int i = 0; i < npush; i++) cpu_write(2'd1, 8'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                cpu_write(2'd3, {2'($urandom), 4'b0, 1'($urandom), ($urandom_range(0, 4) != 0)});
            end else if (!m_en) begin
                cpu_write(2'd3, 8'h01);
            end
            nfull = $urandom_range(0, 3);
            partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if (nfull == 0 && partial == 0) nfull = 1;
            for (int i = 0; i < 8; i++) mbuf[i] = 8'($urandom);
            spi_session(nfull, partial);
            check_regs();
            nread = $urandom_range(0, 5);
            for (int i = 0; i < nread; i++) cpu_read_rx();
            check_regs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL expose parameter FIFO_DEPTH, default 4, meaning RX and TX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL expose ports, one per line:
 i_clk  input  1  system clock, rising-edge.
 i_rst  input  1  reset, asynchronous, active-low.
 i_cs  input  1  CPU register select.
 i_rwb  input  1  1 = read, 0 = write.
 i_addr  input  2  register address.
 i_data  input  8  CPU write data.
 o_data  output  8  CPU read data, combinational from i_addr.
 i_spi_cs  input  1  SPI chip select from controller, active-low, asynchronous.
 i_spi_clk  input  1  SPI clock, CPOL=0, asynchronous.
 i_spi_mosi  input  1  controller-to-target data, asynchronous.
 o_spi_miso  output  1  target-to-controller data.
 o_irq  output  1  interrupt, active-high, level.

Function
REQ-003 SHALL pass i_spi_cs, i_spi_clk and i_spi_mosi each through a 2-flop synchronizer into i_clk, with edge detection on the synchronized copies; supported SCLK half-period SHALL be >= 4 i_clk cycles.
REQ-004 SHALL use SPI mode 1: o_spi_miso updated on SCLK rising edge, MSB first; MOSI sampled on SCLK falling edge, MSB first.
REQ-005 Register map: addr 0 RX data (read pops), addr 1 TX data (write pushes), addr 2 status (read-only), addr 3 control.
REQ-006 Write SHALL take effect on the i_clk rising edge where i_cs=1 and i_rwb=0, using i_data sampled at that edge; read-pop SHALL occur on the rising edge where i_cs=1, i_rwb=1, i_addr=0.
REQ-007 Status bits: [0] RX non-empty, [1] RX full, [2] TX empty, [3] TX full, [4] overrun, [5] underrun, [6] busy (synchronized CS low and enable=1), [7] 0.
REQ-008 Control bits: [0] enable, [1] irq_en, [6] write-1-clear underrun, [7] write-1-clear overrun; read returns {6'b0, irq_en, enable}.
REQ-009 Reading addr 0 with RX empty SHALL return 8'h00 and not pop; reading addr 1 SHALL return 8'h00; writing addr 1 with TX full SHALL be dropped; writes to addr 0/2 SHALL be ignored.
REQ-010 Transfer FSM states IDLE, LOAD, SHIFT: IDLE->LOAD on synchronized CS falling edge with enable=1; LOAD pops TX FIFO into the TX shifter (8'hFF and underrun set if TX empty), bit counter=0, ->SHIFT; SHIFT counts SCLK falling edges; at count 8 the RX byte is pushed and FSM -> LOAD if CS still low.
REQ-011 RX push when RX full SHALL drop the byte and set overrun; existing FIFO contents SHALL be unchanged.
REQ-012 Synchronized CS rising mid-byte SHALL abort: partial RX byte discarded, counter cleared, -> IDLE; the aborted TX byte is not restored.
REQ-013 o_spi_miso SHALL drive shifter[7] while in SHIFT, and 1 in IDLE or when enable=0; it SHALL update within 3 i_clk cycles of the SCLK rising edge.
REQ-014 Clearing enable SHALL force IDLE within 1 cycle; FIFO contents and flags SHALL be retained.
REQ-015 Simultaneous CPU push/pop and SPI pop/push on the same FIFO in one cycle SHALL both take effect; count unchanged for push+pop.
REQ-016 Flag set and write-1-clear in the same cycle: set SHALL win.
REQ-017 o_irq SHALL equal irq_en AND (RX non-empty OR overrun), registered.

Reset
REQ-018 On i_rst low, asynchronously: FIFOs empty, pointers 0, flags 0, control 0, FSM IDLE, shifters 8'hFF, o_spi_miso=1, o_irq=0, synchronizers at idle (CS=1, SCLK=0).
REQ-019 Deassertion SHALL be synchronous to i_clk; an SPI transaction in progress at reset SHALL be ignored until CS next rises then falls.

Verification
REQ-020 Enable, push 8'h55 to TX, controller sends 8'hAA -> controller receives 8'h55, addr 0 reads 8'hAA, status[0] then 0.
REQ-021 TX empty, one byte transferred -> MISO byte 8'hFF, status[5]=1; write 8'h40 to control -> status[5]=0.
REQ-022 FIFO_DEPTH+1 bytes 8'h01..8'h05 sent with no CPU reads -> RX holds 8'h01..8'h04, overrun=1, o_irq=1 with irq_en=1.
REQ-023 CS raised after 4 SCLK edges pairs, then full byte 8'hC3 -> RX contains only 8'hC3.
REQ-024 i_rst asserted mid-byte -> all outputs at reset values immediately; after release, RX empty and next complete byte received correctly.
REQ-025 Two back-to-back bytes with CS held low, TX preloaded 8'h12, 8'h34 -> controller receives 8'h12 then 8'h34, status[2]=1.
